// File: rtl/aes_stream_top.sv
// Stream wrapper around an external fully pipelined, non-stallable cipher core.
// Optional build macro AES_STREAM_STATS_EN adds block counters and a sticky mismatch flag.
module aes_stream_top #(
  parameter int DATA_W     = 128,
  parameter int KEY_W      = 128,
  parameter int LAT        = 21,
  parameter int FIFO_DEPTH = 32,
  parameter int TAG_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] core_state,
  output logic [KEY_W-1:0]  core_key,
  input  logic [DATA_W-1:0] core_out,
  output logic              busy
`ifdef AES_STREAM_STATS_EN
  ,
  output logic [31:0]       blk_in_cnt,
  output logic [31:0]       blk_out_cnt,
  output logic              stat_mismatch
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_C = FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; ready never depends on valid, and valid/payload hold until transfer.
  logic              accept;
  logic              push;
  logic              pop;
  logic [CW:0]       credit_used;

  logic [DATA_W-1:0] state_q;
  logic [KEY_W-1:0]  key_q;
  logic [LAT-1:0]    vld_q;
  logic [TAG_W-1:0]  tag_q [LAT];
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [TAG_W-1:0]  mem_tag_q [FIFO_DEPTH];
  logic              busy_q;

  // Credits cover both blocks inside the core and results already queued, so
  // every block admitted has a guaranteed FIFO slot when it emerges.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign in_ready    = !rst && (credit_used < DEPTH_C);
  assign accept      = in_valid && in_ready;
  assign push        = vld_q[LAT-1];
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready;

  assign out_data    = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_tag     = out_valid ? mem_tag_q[rd_ptr_q]  : '0;
  assign core_state  = state_q;
  assign core_key    = key_q;
  assign busy        = busy_q;

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !push) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!accept && push) begin
      inflight_d = inflight_q - CNT_ONE;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= '0;
      key_q      <= '0;
      vld_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        state_q <= in_data;
        key_q   <= in_key;
      end
      vld_q[0] <= accept;
      tag_q[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      inflight_q <= inflight_d;
      count_q    <= count_d;
      busy_q     <= (inflight_d != '0) || (count_d != '0);
    end
  end

  // Storage is not reset; the read side is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= core_out;
      mem_tag_q[wr_ptr_q]  <= tag_q[LAT-1];
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == DEPTH_C[CW-1:0])));

`ifdef AES_STREAM_STATS_EN
  logic [31:0] blk_in_q;
  logic [31:0] blk_out_q;
  logic        mismatch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_in_q   <= '0;
      blk_out_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (accept) begin
        blk_in_q <= blk_in_q + 32'd1;
      end
      if (pop) begin
        blk_out_q <= blk_out_q + 32'd1;
        if (blk_out_q == blk_in_q) begin
          mismatch_q <= 1'b1;
        end
      end
    end
  end

  assign blk_in_cnt    = blk_in_q;
  assign blk_out_cnt   = blk_out_q;
  assign stat_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_aes_stream_top.sv
// Bench for aes_stream_top: mock LAT-deep cipher core, vector table, queue scoreboard.
module tb_aes_stream_top;
  localparam int DATA_W     = 128;
  localparam int KEY_W      = 128;
  localparam int LAT        = 21;
  localparam int FIFO_DEPTH = 32;
  localparam int TAG_W      = 4;
  localparam int EW         = DATA_W + TAG_W;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIX_C    = 128'hc3a55a3c0f1e2d4b8796a5b4c3d2e1f0;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [KEY_W-1:0]  in_key;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] core_state;
  logic [KEY_W-1:0]  core_key;
  logic [DATA_W-1:0] core_out;
  logic              busy;
`ifdef AES_STREAM_STATS_EN
  logic [31:0]       blk_in_cnt;
  logic [31:0]       blk_out_cnt;
  logic              stat_mismatch;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  aes_stream_top #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .core_state(core_state), .core_key(core_key), .core_out(core_out), .busy(busy)
`ifdef AES_STREAM_STATS_EN
    , .blk_in_cnt(blk_in_cnt), .blk_out_cnt(blk_out_cnt), .stat_mismatch(stat_mismatch)
`endif
  );

  // Mock cipher: the result for the state registered at edge k is on core_out
  // just before edge k+LAT. Only the FIPS-197 pair is real AES.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return {d[95:0], d[127:96]} ^ k ^ MIX_C;
  endfunction

  logic [DATA_W-1:0] core_pipe [LAT-1];
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(core_state, core_key);
    for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[LAT-2];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_pops = 0;
  logic s_acc, s_pop, s_ov, s_ir, s_busy;
  logic [EW-1:0] s_out;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge: drive, sample 1ns later, then cross one rising edge.
  task automatic step(input logic v, input logic [127:0] d, input logic [127:0] k,
                      input logic [3:0] t, input logic ordy);
    in_valid = v; in_data = d; in_key = k; in_tag = t; out_ready = ordy;
    #1;
    s_ir   = in_ready;
    s_ov   = out_valid;
    s_busy = busy;
    s_out  = {out_tag, out_data};
    s_acc  = v && in_ready;
    s_pop  = out_valid && ordy;
    if (s_acc) exp_q.push_back({t, core_fn(d, k)});
    if (s_pop) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_out: got %h expected no output", {out_tag, out_data});
      end else begin
        check("sb_out", {out_tag, out_data}, exp_q.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, rand128(), rand128(), 4'($urandom_range(0, 15)), ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Idle with out_ready=1 until out_valid is seen; lat is sample index after the accept edge.
  task automatic wait_result(output int lat, output logic [EW-1:0] res);
    lat = -1;
    res = '0;
    for (int j = 0; j < LAT + 10; j++) begin
      idle(1'b1);
      if (s_ov) begin
        lat = j;
        res = s_out;
        break;
      end
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic [127:0] key;
    logic [3:0]   tag;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, acc, drops, cnt, p0, bz;
    logic [EW-1:0] res;

    vecs[0] = '{FIPS_PT, FIPS_KEY, 4'd5, FIPS_CT};
    vecs[1] = '{128'h0, 128'h0, 4'd0, 128'hc3a55a3c0f1e2d4b8796a5b4c3d2e1f0};
    vecs[2] = '{{128{1'b1}}, 128'h0, 4'd15, 128'h3c5aa5c3f0e1d2b478695a4b3c2d1e0f};
    vecs[3] = '{128'h0, 128'h1, 4'd9, 128'hc3a55a3c0f1e2d4b8796a5b4c3d2e1f1};
    vecs[4] = '{128'h1, 128'h0, 4'd3, 128'hc3a55a3c0f1e2d4b8796a5b5c3d2e1f0};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out", {out_tag, out_data}, 0);
    check("rst_core_state", core_state, 0);
    check("rst_core_key", core_key, 0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table: latency, result, tag, and core inputs holding across idle junk
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].data, vecs[i].key, vecs[i].tag, 1'b1);
      check("vec_accept", s_acc, 1);
      wait_result(lat, res);
      check("vec_latency", lat, LAT);
      check("vec_result", res, {vecs[i].tag, vecs[i].exp_data});
      check("vec_core_state_hold", core_state, vecs[i].data);
      check("vec_core_key_hold", core_key, vecs[i].key);
      idle(1'b1);
    end

    // Back-to-back stream of 100 blocks
    do_reset();
    drops = 0;
    p0 = n_pops;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, rand128(), rand128(), 4'(i % 16), 1'b1);
      if (!s_acc) drops++;
    end
    check("stream_ready_drops", drops, 0);
    bz = -1;
    for (int j = 0; j < LAT + 10; j++) begin
      idle(1'b1);
      if (!s_busy) begin
        bz = j;
        break;
      end
    end
    check("stream_busy_clear", bz, LAT + 1);
    check("stream_outputs", n_pops - p0, 100);
    check("stream_drained", exp_q.size(), 0);
`ifdef AES_STREAM_STATS_EN
    check("stats_in", blk_in_cnt, 100);
    check("stats_out", blk_out_cnt, 100);
    check("stats_mismatch", stat_mismatch, 0);
`endif

    // Backpressure fills exactly FIFO_DEPTH credits
    do_reset();
    acc = 0;
    for (int i = 0; i < FIFO_DEPTH + LAT + 20; i++) begin
      step(1'b1, rand128(), rand128(), 4'($urandom_range(0, 15)), 1'b0);
      if (s_acc) acc++;
    end
    check("bp_accepts", acc, FIFO_DEPTH);
    check("bp_ready_low", s_ir, 0);
    p0 = n_pops;
    idle(1'b1);
    check("bp_single_pop", s_pop, 1);
    idle(1'b0);
    check("bp_credit_return", s_ir, 1);
    for (int j = 0; j < FIFO_DEPTH + 10; j++) idle(1'b1);
    check("bp_outputs", n_pops - p0, FIFO_DEPTH);
    check("bp_drained", exp_q.size(), 0);

    // Random valid/ready
    do_reset();
    acc = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), rand128(), rand128(), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
      if (s_acc) acc++;
    end
    for (int j = 0; j < LAT + 2 * FIFO_DEPTH + 10; j++) idle(1'b1);
    check("rand_some_accepts", acc > 1000, 1);
    check("rand_drained", exp_q.size(), 0);
    check("rand_busy_idle", s_busy, 0);

    // Reset with 5 queued and 10 in flight
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, rand128(), rand128(), 4'(i), 1'b0);
    for (int j = 0; j < LAT + 2; j++) idle(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, rand128(), rand128(), 4'(i), 1'b0);
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", {out_tag, out_data}, 0);
    @(negedge clk);
    cnt = 0;
    for (int j = 0; j < 2 * LAT; j++) begin
      idle(1'b1);
      if (s_ov) cnt++;
    end
    check("mid_rst_no_stale", cnt, 0);
    step(1'b1, FIPS_PT, FIPS_KEY, 4'd5, 1'b1);
    check("fresh_accept", s_acc, 1);
    wait_result(lat, res);
    check("fresh_latency", lat, LAT);
    check("fresh_result", res, {4'd5, FIPS_CT});
    idle(1'b1);
    check("fresh_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
